mem_refill_arbiter: RTL and testbench
=====================================

// Module: mem_refill_arbiter
// PURPOSE
//  Multi-channel cache-line refill engine between L1 caches and backing memory; replaces the
//  top-level RepReady/RepWord stimulus pins. Arbitrates NUM_REQ miss requests round-robin,
//  issues one line-aligned read per grant, then streams BEATS beats back as RepReady/RepWord.
//  Supports per-channel abort for squashed fetches (branch redirect) without stalling memory.
// PARAMETERS
//  NUM_REQ     2    requester channels (0 = icache_l1, 1 = data cache)
//  ADDR_W      32   request address width
//  BEAT_W      64   refill beat width (RepWord)
//  LINE_BYTES  64   cache line size; BEATS = LINE_BYTES*8/BEAT_W, power of two, >= 2
// PORTS
//  clk           in   1               clock, all state on rising edge
//  reset         in   1               asynchronous, active-low reset
//  ReqValid      in   NUM_REQ         miss request per channel, level, held until ReqAck
//  ReqAddr       in   NUM_REQ*ADDR_W  miss address per channel (channel i at [i*ADDR_W +: ADDR_W])
//  ReqAbort      in   NUM_REQ         discard remaining beats of this channel's active fill
//  ReqAck        out  NUM_REQ         one-hot 1-cycle pulse: request accepted
//  RepReady      out  NUM_REQ         one-hot: RepWord valid for that channel this cycle
//  RepWord       out  BEAT_W          refill beat, shared by all channels
//  RepLast       out  1               marks final beat of line (qualified by any RepReady)
//  MemReqValid   out  1               backing-memory read request
//  MemReqReady   in   1               backing memory accepts request
//  MemReqAddr    out  ADDR_W          line-aligned read address
//  MemRspValid   in   1               returned beat valid (in order, no backpressure)
//  MemRspData    in   BEAT_W          returned beat
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, RR pointer 0, beat count 0, all outputs 0.
//  FSM IDLE -> REQ -> DATA -> IDLE.
//  IDLE: if any ReqValid, grant first set bit at or after RR pointer (wraps at NUM_REQ);
//   latch channel id and ReqAddr with low log2(LINE_BYTES) bits zeroed; pulse ReqAck[g];
//   RR pointer <= g+1 mod NUM_REQ; next REQ. No ReqValid: stay IDLE.
//  REQ: MemReqValid=1, MemReqAddr=latched address, both stable until MemReqReady;
//   on MemReqValid&&MemReqReady -> DATA, beat count 0.
//  DATA: each MemRspValid: RepWord=MemRspData, RepReady[g]=1 same cycle (combinational
//   pass-through, zero added latency), count++; RepLast=1 when count==BEATS-1; then -> IDLE.
//  Minimum turnaround: next ReqAck in the cycle after RepLast beat (no back-to-back in same cycle).
//  Abort: ReqAbort[g] in REQ or DATA sets sticky drop flag; memory request/beats still
//   completed and counted, RepReady forced 0 for the rest of the fill incl. the abort cycle.
//   Flag clears on return to IDLE. ReqAbort of a non-granted channel, or in IDLE, ignored.
//  ReqValid deassert after ReqAck has no effect on the active fill.
//  RepWord = 0 and RepLast = 0 whenever no RepReady is asserted.
//  MemRspValid outside DATA: ignored (assertion error in simulation).
//  Reset mid-fill: immediate return to IDLE; in-flight memory beats afterwards are ignored.
// STRUCTURE
//  Package mem_refill_pkg: typedef enum logic [1:0] {IDLE, REQ, DATA} refill_state_t;
//   localparam function for BEATS and offset bits.
//  Sub-module rr_arbiter #(N) (combinational grant from request vector + pointer, one-hot
//   out); pointer register stays in mem_refill_arbiter.
//  riscv_top instantiates this block with NUM_REQ=1 until the data cache exists.
// TESTING
//  1. Single miss: ReqValid[0]=1, ReqAddr=0x0000_1234 -> ReqAck[0] next cycle,
//     MemReqAddr=0x0000_1200, 8 beats D0..D7 -> RepReady[0] x8, RepLast on D7, back to IDLE.
//  2. Contention: ReqValid=2'b11 from reset -> ch0 served first, ch1 next; repeat with
//     both held -> grants alternate 0,1,0,1.
//  3. MemReqReady held low 5 cycles -> MemReqValid/MemReqAddr stable throughout, no ReqAck re-pulse.
//  4. Abort: ReqAbort[0] at beat 3 -> RepReady[0]=0 for beats 3..7, engine still consumes
//     8 beats, next request granted after beat 7.
//  5. Gapped response: MemRspValid idle cycles between beats -> RepReady only on valid cycles,
//     RepLast exactly on 8th beat.
//  6. Reset (reset=0) asserted at beat 4 -> all outputs 0 asynchronously, RR pointer 0,
//     new request after reset served normally.

Source files
------------

// File: rtl/mem_refill_pkg.sv
// Shared types and size helpers for the cache-line refill engine.
package mem_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } refill_state_t;

  function automatic int calc_beats(input int line_bytes, input int beat_w);
    return (line_bytes * 8) / beat_w;
  endfunction

  function automatic int calc_off_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  // Index width that stays legal for a single requester.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping at N.
// One-hot grant plus its binary index; the pointer register lives with the caller.
module rr_arbiter
  import mem_refill_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = calc_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found     = 1'b1;
        gnt_o[k]  = 1'b1;
        gnt_idx_o = k;
      end
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin cache-line refill engine: one line read per grant, beats passed straight
// through to the granted channel; an abort drops the rest of the fill while memory drains.
module mem_refill_arbiter
  import mem_refill_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ-1:0]        ReqAbort,
  output logic [NUM_REQ-1:0]        ReqAck,
  output logic [NUM_REQ-1:0]        RepReady,
  output logic [BEAT_W-1:0]         RepWord,
  output logic                      RepLast,
  output logic                      MemReqValid,
  input  logic                      MemReqReady,
  output logic [ADDR_W-1:0]         MemReqAddr,
  input  logic                      MemRspValid,
  input  logic [BEAT_W-1:0]         MemRspData
);

  localparam int BEATS = calc_beats(LINE_BYTES, BEAT_W);
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = calc_off_bits(LINE_BYTES);
  localparam int IDX_W = calc_idx_w(NUM_REQ);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  refill_state_t     state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  chan_q, chan_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  req_addr_sel;
  logic               drop_eff;
  logic               last_beat;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i     (ReqValid),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    req_addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) req_addr_sel = ReqAddr[i*ADDR_W +: ADDR_W];
    end
  end

  // The abort cycle itself must already suppress the beat, so the flag is bypassed here.
  assign drop_eff  = drop_q | ReqAbort[chan_q];
  assign last_beat = MemRspValid && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      chan_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (|ReqValid) begin
          chan_d  = gnt_idx;
          addr_d  = req_addr_sel & LINE_MASK;
          rr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ReqAbort[chan_q]) drop_d = 1'b1;
        if (MemReqReady) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ReqAbort[chan_q]) drop_d = 1'b1;
        if (MemRspValid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ReqAck      = '0;
    RepReady    = '0;
    RepWord     = '0;
    RepLast     = 1'b0;
    MemReqValid = 1'b0;
    MemReqAddr  = '0;
    case (state_q)
      IDLE: begin
        if (reset) ReqAck = gnt;
      end
      REQ: begin
        MemReqValid = 1'b1;
        MemReqAddr  = addr_q;
      end
      DATA: begin
        if (MemRspValid && !drop_eff) begin
          RepReady[chan_q] = 1'b1;
          RepWord          = MemRspData;
          RepLast          = last_beat;
        end
      end
      default: ;
    endcase
  end

  a_rsp_only_in_data: assert property (
    @(posedge clk) disable iff (!reset) MemRspValid |-> (state_q == DATA)
  );

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: contention, stalls, aborts, gaps, mid-fill reset.
module tb_mem_refill_arbiter;

  logic         clk;
  logic         reset;
  logic [1:0]   ReqValid;
  logic [63:0]  ReqAddr;
  logic [1:0]   ReqAbort;
  logic [1:0]   ReqAck;
  logic [1:0]   RepReady;
  logic [63:0]  RepWord;
  logic         RepLast;
  logic         MemReqValid;
  logic         MemReqReady;
  logic [31:0]  MemReqAddr;
  logic         MemRspValid;
  logic [63:0]  MemRspData;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] A0_RAW  = 32'h0000_1234;
  localparam logic [31:0] A0_LINE = 32'h0000_1200;
  localparam logic [31:0] A1_RAW  = 32'h0000_ABCD;
  localparam logic [31:0] A1_LINE = 32'h0000_ABC0;

  mem_refill_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .BEAT_W(64), .LINE_BYTES(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ReqValid    (ReqValid),
    .ReqAddr     (ReqAddr),
    .ReqAbort    (ReqAbort),
    .ReqAck      (ReqAck),
    .RepReady    (RepReady),
    .RepWord     (RepWord),
    .RepLast     (RepLast),
    .MemReqValid (MemReqValid),
    .MemReqReady (MemReqReady),
    .MemReqAddr  (MemReqAddr),
    .MemRspValid (MemRspValid),
    .MemRspData  (MemRspData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after a rising edge in IDLE with ReqValid already driven.
  task automatic serve(input int ch, input logic [31:0] exp_addr, input int stall,
                       input int gap, input int abort_beat, input bit clr_vld);
    logic [1:0]  onehot;
    logic [63:0] beat;
    bit          live;
    onehot = 2'b01 << ch;
    #2;
    chk("ack", 64'(ReqAck), 64'(onehot));
    tick();
    if (clr_vld) ReqValid = 2'b00;
    MemReqReady = 1'b0;
    for (int s = 0; s < stall; s++) begin
      #2;
      chk("stall_vld", 64'(MemReqValid), 64'd1);
      chk("stall_addr", 64'(MemReqAddr), 64'(exp_addr));
      chk("stall_ack", 64'(ReqAck), 64'd0);
      tick();
    end
    MemReqReady = 1'b1;
    #2;
    chk("req_vld", 64'(MemReqValid), 64'd1);
    chk("req_addr", 64'(MemReqAddr), 64'(exp_addr));
    chk("req_ack", 64'(ReqAck), 64'd0);
    tick();
    MemReqReady = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        MemRspValid = 1'b0;
        #2;
        chk("gap_rdy", 64'(RepReady), 64'd0);
        chk("gap_word", RepWord, 64'd0);
        tick();
      end
      beat        = 64'hD0D0_0000_0000_0000 | 64'(b);
      MemRspValid = 1'b1;
      MemRspData  = beat;
      ReqAbort    = (b == abort_beat) ? onehot : 2'b00;
      live        = (b < abort_beat);
      #2;
      chk("beat_rdy", 64'(RepReady), live ? 64'(onehot) : 64'd0);
      chk("beat_word", RepWord, live ? beat : 64'd0);
      chk("beat_last", 64'(RepLast), (live && b == 7) ? 64'd1 : 64'd0);
      tick();
    end
    MemRspValid = 1'b0;
    MemRspData  = '0;
    ReqAbort    = 2'b00;
  endtask

  initial begin
    reset       = 1'b0;
    ReqValid    = 2'b11;
    ReqAddr     = {A1_RAW, A0_RAW};
    ReqAbort    = 2'b00;
    MemReqReady = 1'b0;
    MemRspValid = 1'b0;
    MemRspData  = '0;
    #3;
    chk("rst_ack", 64'(ReqAck), 64'd0);
    chk("rst_mvld", 64'(MemReqValid), 64'd0);
    chk("rst_maddr", 64'(MemReqAddr), 64'd0);
    chk("rst_rdy", 64'(RepReady), 64'd0);
    chk("rst_word", RepWord, 64'd0);
    chk("rst_last", 64'(RepLast), 64'd0);
    tick();
    reset = 1'b1;

    // Both channels held: grants alternate starting at channel 0.
    serve(0, A0_LINE, 0, 0, 8, 1'b0);
    serve(1, A1_LINE, 0, 0, 8, 1'b0);
    serve(0, A0_LINE, 0, 0, 8, 1'b0);
    serve(1, A1_LINE, 0, 0, 8, 1'b0);
    ReqValid = 2'b00;
    #2;
    chk("idle_ack", 64'(ReqAck), 64'd0);
    chk("idle_mvld", 64'(MemReqValid), 64'd0);
    tick();
    #2;
    chk("idle_hold", 64'(MemReqValid), 64'd0);
    tick();

    // Single miss, request dropped after ack.
    ReqValid = 2'b01;
    serve(0, A0_LINE, 0, 0, 8, 1'b1);

    // Memory request stalled for 5 cycles.
    ReqValid = 2'b10;
    serve(1, A1_LINE, 5, 0, 8, 1'b1);

    // Abort at beat 3, next request granted right after the last beat.
    ReqValid = 2'b01;
    serve(0, A0_LINE, 0, 0, 3, 1'b1);
    ReqValid = 2'b10;
    serve(1, A1_LINE, 0, 0, 8, 1'b1);

    // Gapped response beats.
    ReqValid = 2'b01;
    serve(0, A0_LINE, 0, 2, 8, 1'b1);

    // Reset during beat 4 of a channel-0 fill (pointer sits at 1 beforehand).
    ReqValid = 2'b01;
    #2;
    chk("r6_ack", 64'(ReqAck), 64'd1);
    tick();
    ReqValid    = 2'b00;
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    for (int b = 0; b < 4; b++) begin
      MemRspValid = 1'b1;
      MemRspData  = 64'h5A00 + 64'(b);
      #2;
      chk("r6_beat", 64'(RepReady), 64'd1);
      tick();
    end
    MemRspValid = 1'b1;
    MemRspData  = 64'h5A04;
    #1;
    chk("r6_pre", 64'(RepReady), 64'd1);
    reset = 1'b0;
    #1;
    chk("r6_rdy", 64'(RepReady), 64'd0);
    chk("r6_word", RepWord, 64'd0);
    chk("r6_mvld", 64'(MemReqValid), 64'd0);
    MemRspValid = 1'b0;
    MemRspData  = '0;
    tick();
    tick();
    reset    = 1'b1;
    ReqValid = 2'b11;
    serve(0, A0_LINE, 0, 0, 8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
